control_sequencer: RTL and testbench

- Microcode controller for the 8-bit CPU datapath.
- Consumes the instruction register's opcode nibble and the flags register outputs.
- Produces the 16-bit control word whose bits drive the load/enable inputs of the A, B, MAR, IR, output and flags registers, plus the bus drivers.
- Sits directly upstream of every datapath register. Instructions take 3–5 T-states; no idle steps are padded.

---
 rtl/control_sequencer.sv | 127 ++++++++++++
 tb/tb_control_sequencer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - microcode sequencer producing the 16-bit datapath control word
module control_sequencer #(
    parameter int MAX_STEP = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [3:0]  opcode,
    input  logic        flag_c,
    input  logic        flag_z,
    output logic [15:0] ctrl,
    output logic [2:0]  step,
    output logic        halted
);

    localparam logic [15:0] HLT = 16'h8000;
    localparam logic [15:0] MI  = 16'h4000;
    localparam logic [15:0] RI  = 16'h2000;
    localparam logic [15:0] RO  = 16'h1000;
    localparam logic [15:0] IO  = 16'h0800;
    localparam logic [15:0] II  = 16'h0400;
    localparam logic [15:0] AI  = 16'h0200;
    localparam logic [15:0] AO  = 16'h0100;
    localparam logic [15:0] EO  = 16'h0080;
    localparam logic [15:0] SU  = 16'h0040;
    localparam logic [15:0] BI  = 16'h0020;
    localparam logic [15:0] OI  = 16'h0010;
    localparam logic [15:0] CE  = 16'h0008;
    localparam logic [15:0] CO  = 16'h0004;
    localparam logic [15:0] J   = 16'h0002;
    localparam logic [15:0] FI  = 16'h0001;

    localparam logic [2:0] MAX_S = 3'(MAX_STEP);

    localparam logic [3:0] OP_LDA = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0011;
    localparam logic [3:0] OP_STA = 4'b0100;
    localparam logic [3:0] OP_LDI = 4'b0101;
    localparam logic [3:0] OP_JMP = 4'b0110;
    localparam logic [3:0] OP_JC  = 4'b0111;
    localparam logic [3:0] OP_JZ  = 4'b1000;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    logic [2:0]  last_step;
    logic [15:0] uword;

    // Final T-state of the current opcode; undefined opcodes end at T2 like NOP
    always_comb begin
        last_step = 3'd2;
        case (opcode)
            OP_LDA, OP_STA: last_step = 3'd3;
            OP_ADD, OP_SUB: last_step = 3'd4;
            default:        last_step = 3'd2;
        endcase
    end

    // Microcode word for the current step; flags only matter in T2
    always_comb begin
        uword = 16'h0000;
        case (step)
            3'd0: uword = CO | MI;
            3'd1: uword = RO | II | CE;
            3'd2: begin
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: uword = IO | MI;
                    OP_LDI: uword = IO | AI;
                    OP_JMP: uword = IO | J;
                    OP_JC:  uword = flag_c ? (IO | J) : 16'h0000;
                    OP_JZ:  uword = flag_z ? (IO | J) : 16'h0000;
                    OP_OUT: uword = AO | OI;
                    OP_HLT: uword = HLT;
                    default: uword = 16'h0000;
                endcase
            end
            3'd3: begin
                case (opcode)
                    OP_LDA:         uword = RO | AI;
                    OP_ADD, OP_SUB: uword = RO | BI;
                    OP_STA:         uword = AO | RI;
                    default:        uword = 16'h0000;
                endcase
            end
            3'd4: begin
                case (opcode)
                    OP_ADD:  uword = EO | AI | FI;
                    OP_SUB:  uword = EO | SU | AI | FI;
                    default: uword = 16'h0000;
                endcase
            end
            default: uword = 16'h0000;
        endcase
    end

    // Output gating: reset wins, then halt, then the step enable
    always_comb begin
        if (rst) begin
            ctrl = 16'h0000;
        end else if (halted) begin
            ctrl = HLT;
        end else if (!en || step > MAX_S) begin
            ctrl = 16'h0000;
        end else begin
            ctrl = uword;
        end
    end

    // Step counter and halt latch; HLT parks the sequencer at T2
    always_ff @(posedge clk) begin
        if (rst) begin
            step   <= 3'd0;
            halted <= 1'b0;
        end else if (!halted && en) begin
            if (step > MAX_S) begin
                step <= 3'd0;
            end else if (opcode == OP_HLT && step == 3'd2) begin
                halted <= 1'b1;
            end else if (step >= last_step) begin
                step <= 3'd0;
            end else begin
                step <= step + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - directed bench with per-cycle reference model for control_sequencer
module tb_control_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [3:0]  opcode;
    logic        flag_c;
    logic        flag_z;
    logic [15:0] ctrl;
    logic [2:0]  step;
    logic        halted;

    int checks = 0;
    int errors = 0;

    control_sequencer #(.MAX_STEP(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .opcode (opcode),
        .flag_c (flag_c),
        .flag_z (flag_z),
        .ctrl   (ctrl),
        .step   (step),
        .halted (halted)
    );

    always #5 clk = ~clk;

    // Reference microprogram: per-opcode word list and instruction length
    logic [15:0] prog [16][5];
    int          len  [16];
    int          m_step;
    bit          m_halted;
    bit          cmp_en = 1'b0;

    initial begin
        for (int op = 0; op < 16; op++) begin
            len[op] = 3;
            prog[op][0] = 16'h4004;
            prog[op][1] = 16'h1408;
            for (int k = 2; k < 5; k++) prog[op][k] = 16'h0000;
        end
        prog[1][2]  = 16'h4800; prog[1][3] = 16'h1200; len[1] = 4;
        prog[2][2]  = 16'h4800; prog[2][3] = 16'h1020; prog[2][4] = 16'h0281; len[2] = 5;
        prog[3][2]  = 16'h4800; prog[3][3] = 16'h1020; prog[3][4] = 16'h02C1; len[3] = 5;
        prog[4][2]  = 16'h4800; prog[4][3] = 16'h2100; len[4] = 4;
        prog[5][2]  = 16'h0A00;
        prog[6][2]  = 16'h0802;
        prog[7][2]  = 16'h0802;
        prog[8][2]  = 16'h0802;
        prog[14][2] = 16'h0110;
        prog[15][2] = 16'h8000;
    end

    function automatic logic [15:0] model_ctrl();
        logic [15:0] w;
        if (rst) return 16'h0000;
        if (m_halted) return 16'h8000;
        if (!en) return 16'h0000;
        w = prog[opcode][m_step];
        if (m_step == 2 && opcode == 4'd7 && !flag_c) w = 16'h0000;
        if (m_step == 2 && opcode == 4'd8 && !flag_z) w = 16'h0000;
        return w;
    endfunction

    // Model state advance
    always @(posedge clk) begin
        if (rst) begin
            m_step   <= 0;
            m_halted <= 1'b0;
        end else if (!m_halted && en) begin
            if (opcode == 4'hF && m_step == 2) m_halted <= 1'b1;
            else if (m_step + 1 >= len[opcode]) m_step <= 0;
            else m_step <= m_step + 1;
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (cmp_en) begin
            checks++;
            if (ctrl !== model_ctrl() || step !== 3'(m_step) || halted !== m_halted) begin
                errors++;
                $display("FAIL model t=%0t: ctrl=%h step=%0d halted=%0d, required ctrl=%h step=%0d halted=%0d",
                         $time, ctrl, step, halted, model_ctrl(), m_step, m_halted);
            end
        end
    end

    // Check literal expectations at the falling edge, then move past the next rising edge
    task automatic cyc(input string name, input logic [15:0] ec, input logic [2:0] es, input logic eh);
        @(negedge clk);
        checks++;
        if (ctrl !== ec || step !== es || halted !== eh) begin
            errors++;
            $display("FAIL %s: ctrl=%h step=%0d halted=%0d, required ctrl=%h step=%0d halted=%0d",
                     name, ctrl, step, halted, ec, es, eh);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0]  ops [4];
        logic [15:0] t2w [4];
        ops[0] = 4'h0; t2w[0] = 16'h0000;
        ops[1] = 4'h5; t2w[1] = 16'h0A00;
        ops[2] = 4'h6; t2w[2] = 16'h0802;
        ops[3] = 4'hE; t2w[3] = 16'h0110;

        rst = 1'b1; en = 1'b0; opcode = 4'h0; flag_c = 1'b0; flag_z = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        cmp_en = 1'b1;
        cyc("reset", 16'h0000, 3'd0, 1'b0);

        rst = 1'b0; en = 1'b1; opcode = 4'h1;
        cyc("lda_t0", 16'h4004, 3'd0, 1'b0);
        cyc("lda_t1", 16'h1408, 3'd1, 1'b0);
        cyc("lda_t2", 16'h4800, 3'd2, 1'b0);
        cyc("lda_t3", 16'h1200, 3'd3, 1'b0);
        cyc("lda_wrap", 16'h4004, 3'd0, 1'b0);

        opcode = 4'h2;
        cyc("add_t1", 16'h1408, 3'd1, 1'b0);
        cyc("add_t2", 16'h4800, 3'd2, 1'b0);
        cyc("add_t3", 16'h1020, 3'd3, 1'b0);
        cyc("add_t4", 16'h0281, 3'd4, 1'b0);
        cyc("add_wrap", 16'h4004, 3'd0, 1'b0);
        opcode = 4'h3;
        cyc("sub_t1", 16'h1408, 3'd1, 1'b0);
        cyc("sub_t2", 16'h4800, 3'd2, 1'b0);
        cyc("sub_t3", 16'h1020, 3'd3, 1'b0);
        cyc("sub_t4", 16'h02C1, 3'd4, 1'b0);
        cyc("sub_wrap", 16'h4004, 3'd0, 1'b0);

        opcode = 4'h7; flag_c = 1'b0;
        cyc("jc0_t1", 16'h1408, 3'd1, 1'b0);
        cyc("jc0_t2", 16'h0000, 3'd2, 1'b0);
        flag_c = 1'b1;
        cyc("jc0_wrap", 16'h4004, 3'd0, 1'b0);
        cyc("jc1_t1", 16'h1408, 3'd1, 1'b0);
        cyc("jc1_t2", 16'h0802, 3'd2, 1'b0);
        cyc("jc1_wrap", 16'h4004, 3'd0, 1'b0);
        flag_c = 1'b0;

        opcode = 4'h8; flag_z = 1'b1;
        cyc("jz1_t1", 16'h1408, 3'd1, 1'b0);
        cyc("jz1_t2", 16'h0802, 3'd2, 1'b0);
        cyc("jz1_wrap", 16'h4004, 3'd0, 1'b0);
        flag_z = 1'b0;

        for (int i = 0; i < 4; i++) begin
            opcode = ops[i];
            cyc("short_t1", 16'h1408, 3'd1, 1'b0);
            cyc("short_t2", t2w[i], 3'd2, 1'b0);
            cyc("short_wrap", 16'h4004, 3'd0, 1'b0);
        end

        opcode = 4'h4;
        cyc("sta_t1", 16'h1408, 3'd1, 1'b0);
        cyc("sta_t2", 16'h4800, 3'd2, 1'b0);
        en = 1'b0;
        for (int i = 0; i < 4; i++) cyc("sta_frozen", 16'h0000, 3'd3, 1'b0);
        en = 1'b1;
        cyc("sta_t3", 16'h2100, 3'd3, 1'b0);
        cyc("sta_wrap", 16'h4004, 3'd0, 1'b0);

        opcode = 4'h2;
        cyc("addr_t1", 16'h1408, 3'd1, 1'b0);
        cyc("addr_t2", 16'h4800, 3'd2, 1'b0);
        cyc("addr_t3", 16'h1020, 3'd3, 1'b0);
        rst = 1'b1;
        cyc("addr_rst", 16'h0000, 3'd4, 1'b0);
        rst = 1'b0;
        cyc("addr_after_rst", 16'h4004, 3'd0, 1'b0);

        opcode = 4'hA;
        cyc("undef_t1", 16'h1408, 3'd1, 1'b0);
        cyc("undef_t2", 16'h0000, 3'd2, 1'b0);
        cyc("undef_wrap", 16'h4004, 3'd0, 1'b0);

        opcode = 4'hF;
        cyc("hlt_t1", 16'h1408, 3'd1, 1'b0);
        cyc("hlt_t2", 16'h8000, 3'd2, 1'b0);
        for (int i = 0; i < 10; i++) begin
            en = i[0];
            cyc("halted_hold", 16'h8000, 3'd2, 1'b1);
        end
        en = 1'b1; rst = 1'b1;
        cyc("halt_rst", 16'h0000, 3'd2, 1'b1);
        rst = 1'b0;
        cyc("halt_cleared", 16'h4004, 3'd0, 1'b0);
        cyc("post_halt_t1", 16'h1408, 3'd1, 1'b0);

        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
